// File: rtl/bsg_async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers: Gray/binary conversion
// and the default pointer geometry.
package bsg_async_fifo_pkg;

   localparam int lg_size_default_lp = 3;
   localparam int ptr_width_lp       = lg_size_default_lp + 1;
   localparam int max_width_lp       = 32;

   typedef logic [max_width_lp-1:0] word_t;

   // Width-generic by zero extension: callers cast in and truncate the result.
   function automatic word_t bsg_bin2gray(input word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic word_t bsg_gray2bin(input word_t gray);
      word_t bin;
      bin = gray;
      for (int i = max_width_lp - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/bsg_async_fifo_wptr_ctrl_if.sv
// Write-side bundle between the producer/crossing logic and the write pointer
// controller.
interface bsg_async_fifo_wptr_ctrl_if
   import bsg_async_fifo_pkg::*;
   #(parameter int lg_size_p = lg_size_default_lp);

   localparam int ptr_w_lp = lg_size_p + 1;

   logic                 enq_i;
   logic [ptr_w_lp-1:0]  r_ptr_gray_sync_i;
   logic                 w_en_o;
   logic [lg_size_p-1:0] w_addr_o;
   logic [ptr_w_lp-1:0]  w_ptr_gray_o;
   logic                 full_o;
   logic [ptr_w_lp-1:0]  count_o;
   logic                 overflow_o;

   modport master (
      output enq_i, r_ptr_gray_sync_i,
      input  w_en_o, w_addr_o, w_ptr_gray_o, full_o, count_o, overflow_o
   );

   modport slave (
      input  enq_i, r_ptr_gray_sync_i,
      output w_en_o, w_addr_o, w_ptr_gray_o, full_o, count_o, overflow_o
   );

endinterface

// File: rtl/bsg_gray_to_binary.sv
// Gray to binary conversion as an XOR-prefix chain from the MSB down.
// Shared by the read- and write-side pointer controllers.
module bsg_gray_to_binary #(
   parameter int width_p = 4
) (
   input  logic [width_p-1:0] gray_i,
   output logic [width_p-1:0] binary_o
);

   // Each binary bit is the parity of all Gray bits at or above it.
   for (genvar i = 0; i < width_p; i++) begin : g_bit
      assign binary_o[i] = ^gray_i[width_p-1:i];
   end

endmodule

// File: rtl/bsg_async_fifo_wptr_ctrl.sv
// Async FIFO write pointer controller: binary/Gray write pointers, full,
// occupancy and sticky overflow, all in the write clock domain.
module bsg_async_fifo_wptr_ctrl
   import bsg_async_fifo_pkg::*;
   #(parameter int lg_size_p = lg_size_default_lp)
(
   input  logic                         clk_i,
   input  logic                         reset_i,
   bsg_async_fifo_wptr_ctrl_if.slave    wif
);

   localparam int ptr_w_lp = lg_size_p + 1;
   // Full means the pointers differ only in their top two Gray bits.
   localparam logic [ptr_w_lp-1:0] full_xor_lp = ptr_w_lp'(3) << (ptr_w_lp - 2);

   logic [ptr_w_lp-1:0] w_ptr_bin_r;
   logic [ptr_w_lp-1:0] w_ptr_gray_r;
   logic                overflow_r;

   logic [ptr_w_lp-1:0] w_ptr_bin_n;
   logic [ptr_w_lp-1:0] w_ptr_gray_n;
   logic [ptr_w_lp-1:0] r_ptr_bin;
   logic                full;
   logic                accept;

   bsg_gray_to_binary #(.width_p(ptr_w_lp)) r_g2b (
      .gray_i   (wif.r_ptr_gray_sync_i),
      .binary_o (r_ptr_bin)
   );

   assign full         = ((w_ptr_gray_r ^ wif.r_ptr_gray_sync_i) == full_xor_lp);
   assign accept       = wif.enq_i & ~full & ~reset_i;
   assign w_ptr_bin_n  = w_ptr_bin_r + ptr_w_lp'(1);
   assign w_ptr_gray_n = ptr_w_lp'(bsg_bin2gray(word_t'(w_ptr_bin_n)));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         w_ptr_bin_r  <= '0;
         w_ptr_gray_r <= '0;
         overflow_r   <= 1'b0;
      end else begin
         if (accept) begin
            w_ptr_bin_r  <= w_ptr_bin_n;
            w_ptr_gray_r <= w_ptr_gray_n;
         end
         if (wif.enq_i & full) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Gray pointer leaves straight from its flop so the crossing sees no glitches.
   assign wif.w_ptr_gray_o = w_ptr_gray_r;
   assign wif.w_en_o       = accept;
   assign wif.w_addr_o     = w_ptr_bin_r[lg_size_p-1:0];
   assign wif.full_o       = full;
   assign wif.count_o      = w_ptr_bin_r - r_ptr_bin;
   assign wif.overflow_o   = overflow_r;

endmodule

// File: tb/tb_bsg_async_fifo_wptr_ctrl.sv
// Scoreboard bench for bsg_async_fifo_wptr_ctrl (lg_size_p = 3): directed
// vectors push expectations, a negedge monitor pops and compares.
module tb_bsg_async_fifo_wptr_ctrl;
   import bsg_async_fifo_pkg::*;

   localparam int lg_size_lp = 3;

   typedef struct {
      string      tag;
      logic       rst;
      logic       w_en;
      logic [2:0] addr;
      logic [3:0] gray;
      logic       full;
      logic [3:0] count;
      logic       ovf;
   } exp_t;

   // Hand-written Gray code for binary 0..15.
   logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   logic clk = 1'b0;
   logic reset;
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_bin    = 0;
   logic m_ovf    = 1'b0;
   logic [3:0] prev_gray;
   logic       have_prev = 1'b0;

   always #5 clk = ~clk;

   bsg_async_fifo_wptr_ctrl_if #(.lg_size_p(lg_size_lp)) wif ();

   bsg_async_fifo_wptr_ctrl #(.lg_size_p(lg_size_lp)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .wif     (wif)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus and push what the outputs must show during it.
   task automatic step(input string tag, input logic rst, input logic enq, input int rbin);
      exp_t e;
      int   diff;
      @(posedge clk);
      #1;
      reset                 = rst;
      wif.enq_i             = enq;
      wif.r_ptr_gray_sync_i = gray_tab[rbin % 16];
      diff    = (m_bin - (rbin % 16) + 16) % 16;
      e.tag   = tag;
      e.rst   = rst;
      e.full  = (diff == 8);
      e.count = 4'(diff);
      e.w_en  = enq & ~e.full & ~rst;
      e.addr  = 3'(m_bin);
      e.gray  = gray_tab[m_bin];
      e.ovf   = m_ovf;
      sb_q.push_back(e);
      if (rst) begin
         m_bin = 0;
         m_ovf = 1'b0;
      end else begin
         if (enq && !e.full) m_bin = (m_bin + 1) % 16;
         if (enq && e.full)  m_ovf = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({e.tag, " w_en"},     32'(wif.w_en_o),       32'(e.w_en));
         check({e.tag, " w_addr"},   32'(wif.w_addr_o),     32'(e.addr));
         check({e.tag, " w_gray"},   32'(wif.w_ptr_gray_o), 32'(e.gray));
         check({e.tag, " full"},     32'(wif.full_o),       32'(e.full));
         check({e.tag, " count"},    32'(wif.count_o),      32'(e.count));
         check({e.tag, " overflow"}, 32'(wif.overflow_o),   32'(e.ovf));
         if (e.rst) begin
            have_prev = 1'b0;
         end else begin
            if (have_prev && (wif.w_ptr_gray_o !== prev_gray))
               check({e.tag, " gray_hamming"}, $countones(wif.w_ptr_gray_o ^ prev_gray), 1);
            prev_gray = wif.w_ptr_gray_o;
            have_prev = 1'b1;
         end
      end
   end

   initial begin
      int budget;
      reset                 = 1'b1;
      wif.enq_i             = 1'b1;
      wif.r_ptr_gray_sync_i = '0;

      // Reset held with enq asserted, then eight back-to-back accepts.
      repeat (3) step("reset", 1'b1, 1'b1, 0);
      for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b1, 0);
      // Writes against a full FIFO set the sticky overflow.
      repeat (2) step("full_enq", 1'b0, 1'b1, 0);
      repeat (2) step("ovf_sticky", 1'b0, 1'b0, 0);
      // Reader frees one entry in the same cycle as an enqueue.
      step("reader_frees", 1'b0, 1'b1, 1);
      repeat (2) step("count5", 1'b0, 1'b0, 4);
      // Mid-stream reset with the read side reset alongside.
      step("mid_reset", 1'b1, 1'b1, 4);
      step("mid_reset", 1'b1, 1'b1, 0);
      // Twenty accepts with the reader trailing by three: pointer wraps.
      for (int i = 0; i < 20; i++) step("wrap", 1'b0, 1'b1, (i >= 3) ? i - 3 : 0);
      repeat (3) step("wrap_tail", 1'b0, 1'b0, 17);

      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      if (sb_q.size() != 0) check("scoreboard_drain", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
